// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Imported by the interface, the storage array and the top level.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Accept decisions for one clock cycle.
  typedef struct packed {
    logic wr;
    logic rd;
  } fifo_acc_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for the FIFO.
// The dut modport sits on the FIFO side; the tb modport sits on the driving side.
interface fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  modport dut (
    input  clk, rst, wr_en, rd_en, din,
    output dout, full, empty
  );

  modport tb (
    input  clk, rst, dout, full, empty,
    output wr_en, rd_en, din
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered read port.
// Only the read register is reset; the array keeps whatever it held.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [addr_w(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [addr_w(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A same-address write in this cycle is not visible here: the old word is returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrapping pointers, occupancy counter, status flags and
// one-cycle overflow/underflow pulses around a registered-read storage array.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH   // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_if.dut                    bus,
  output logic [addr_w(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int          AW       = addr_w(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full_w, empty_w;
  fifo_acc_t     acc;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign acc.rd = bus.rd_en & ~empty_w;
  assign acc.wr = bus.wr_en & (~full_w | acc.rd);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = bus.wr_en & ~acc.wr;
    underflow_d = bus.rd_en & ~acc.rd;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (acc.wr) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (acc.rd) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({acc.wr, acc.rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (acc.wr),
    .wr_addr_i (wptr_q),
    .wr_data_i (bus.din),
    .rd_en_i   (acc.rd),
    .rd_addr_i (rptr_q),
    .rd_data_o (bus.dout)
  );

  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus randomized traffic,
// all compared each cycle against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int DEPTH = DEFAULT_DEPTH;
  localparam int AW    = addr_w(DEPTH);

  logic          clk;
  logic          rst;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  fifo_if #(.WIDTH(WIDTH)) bus (.clk(clk), .rst(rst));

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Rising edges at 10, 20, 30 ... so reset release at 15 ns lands mid-cycle.
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5 clk = 1'b0;
      #5;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a queue, plus the expected registered outputs.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_dout"},  32'(bus.dout),  32'(exp_dout));
    check_eq({tag, "_count"}, 32'(count),     32'(model_q.size()));
    check_eq({tag, "_full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check_eq({tag, "_ovf"},   32'(overflow),  32'(exp_ovf));
    check_eq({tag, "_unf"},   32'(underflow), 32'(exp_unf));
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
  endtask

  // Advance one clock edge, updating the model from the inputs presented to it.
  task automatic cycle(input string tag);
    bit rd_acc;
    bit wr_acc;
    rd_acc  = bus.rd_en && (model_q.size() != 0);
    wr_acc  = bus.wr_en && ((model_q.size() < DEPTH) || rd_acc);
    exp_ovf = bus.wr_en && !wr_acc;
    exp_unf = bus.rd_en && !rd_acc;
    if (rd_acc) exp_dout = model_q.pop_front();
    if (wr_acc) model_q.push_back(bus.din);
    @(posedge clk);
    #1;
    $display("[TB] %-8s t=%0t wr=%b rd=%b din=%h -> dout=%h count=%0d full=%b empty=%b ovf=%b unf=%b",
             tag, $time, bus.wr_en, bus.rd_en, bus.din, bus.dout, count,
             bus.full, bus.empty, overflow, underflow);
    check_all(tag);
  endtask

  // Called just after a rising edge: pulls reset low mid-cycle and releases it before the next edge.
  task automatic async_reset_pulse(input string tag);
    drive(1'b0, 1'b0, '0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    $display("[TB] %-8s t=%0t async reset asserted, count=%0d empty=%b", tag, $time, count, bus.empty);
    check_all(tag);
    #3 rst = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] t2_data [3];
    int wp [3];
    int rp [3];
    t2_data = '{8'h24, 8'h81, 8'h09};
    wp = '{80, 50, 20};
    rp = '{20, 50, 80};

    // 1: reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    model_reset();
    #5;
    check_all("rst_hold");
    #10 rst = 1'b1;
    #1;
    check_all("rst_rel");
    for (int i = 0; i < 2; i++) begin
      cycle("idle");
    end

    // 2: three writes, three ordered reads
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, t2_data[i]);
      cycle("t2_wr");
    end
    check_eq("t2_count3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, '0);
      cycle("t2_rd");
      check_eq("t2_order", 32'(bus.dout), 32'(t2_data[i]));
    end
    check_eq("t2_empty", 32'(bus.empty), 32'd1);

    // 3: fill, rejected fifth write, drain
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, WIDTH'(8'h30 + i));
      cycle("t3_wr");
    end
    check_eq("t3_full", 32'(bus.full), 32'd1);
    drive(1'b1, 1'b0, 8'hFF);
    cycle("t3_ovf");
    check_eq("t3_ovf_pulse", 32'(overflow), 32'd1);
    drive(1'b0, 1'b0, '0);
    cycle("t3_idle");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      cycle("t3_rd");
    end

    // 4: full with simultaneous read+write across a pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, WIDTH'($urandom));
      cycle("t4_fill");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, WIDTH'(8'hA0 + i));
      cycle("t4_rw");
      check_eq("t4_full_held", 32'(bus.full), 32'd1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      cycle("t4_drain");
    end

    // 5: underflow, then write+read while empty
    drive(1'b0, 1'b1, '0);
    cycle("t5_unf");
    check_eq("t5_unf_pulse", 32'(underflow), 32'd1);
    drive(1'b0, 1'b0, '0);
    cycle("t5_idle");
    drive(1'b1, 1'b1, 8'h5A);
    cycle("t5_rw");
    check_eq("t5_count1", 32'(count), 32'd1);
    drive(1'b0, 1'b1, '0);
    cycle("t5_rd");
    check_eq("t5_data", 32'(bus.dout), 32'h5A);

    // 6: reset mid-operation discards stored data
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, WIDTH'(8'h60 + i));
      cycle("t6_wr");
    end
    async_reset_pulse("t6_rst");
    drive(1'b1, 1'b0, 8'hC3);
    cycle("t6_wr2");
    drive(1'b0, 1'b1, '0);
    cycle("t6_rd2");
    check_eq("t6_data", 32'(bus.dout), 32'hC3);
    cycle("t6_rd3");

    // Randomized traffic with write-heavy, balanced and read-heavy phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        if (ph == 1 && i == 75) begin
          async_reset_pulse("rnd_rst");
        end
        drive(1'b1 && ($urandom_range(99) < wp[ph]),
              1'b1 && ($urandom_range(99) < rp[ph]),
              WIDTH'($urandom));
        cycle("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
